// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Also holds the two-way round-robin pick used by rr_arb2.
package sp_ram_pkg;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 8;
   localparam int RAM_DEPTH = 1 << ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } arb_state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_idx_t;

   // On contention the requester that did not win last time is picked.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input req_idx_t last);
      logic [1:0] g;
      case (req)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = (last == REQ_B) ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered last-winner pointer.
// The pointer resets to "B last" so A wins the first contention.
module rr_arb2
   import sp_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   req_idx_t last_r;
   logic [1:0] gnt_s;

   // grant decision from live requests and the stored last winner
   always_comb begin
      gnt_s = rr_pick(req, last_r);
   end

   assign gnt = gnt_s;

   // pointer follows every issued grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r <= REQ_B;
      end else if (update && (gnt_s != 2'b00)) begin
         last_r <= gnt_s[1] ? REQ_B : REQ_A;
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between requesters A and B, with a zero-fill engine.
// Define SP_RAM_ARB_OUTREG_EN to register read data per requester (2-cycle read latency).
module sp_ram_arbiter #(
   parameter int                ADDR_W    = sp_ram_pkg::ADDR_W,
   parameter int                DATA_W    = sp_ram_pkg::DATA_W,
   parameter logic [DATA_W-1:0] CLR_VALUE = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              ram_ce,
   output logic              ram_oce,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_reset,
   input  logic [DATA_W-1:0] ram_dout
);
   import sp_ram_pkg::*;

   localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

   arb_state_t        state_r;
   arb_state_t        state_next_s;
   logic [ADDR_W-1:0] clr_cnt_r;
   logic [ADDR_W-1:0] last_ad_r;
   logic [DATA_W-1:0] last_din_r;
   logic              clr_done_r;
   logic              rd_a_r;
   logic              rd_b_r;
   logic              idle_s;
   logic              clr_last_s;
   logic [1:0]        req_s;
   logic [1:0]        gnt_s;
   logic              ram_ce_s;
   logic              ram_wre_s;
   logic [ADDR_W-1:0] ram_ad_s;
   logic [DATA_W-1:0] ram_din_s;

   assign idle_s     = (state_r == IDLE);
   assign clr_last_s = (clr_cnt_r == CNT_LAST);
   // requesters are masked while the fill engine owns the RAM
   assign req_s      = idle_s ? {b_req, a_req} : 2'b00;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_s),
      .update (idle_s),
      .gnt    (gnt_s)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // next-state: start on command, return after the last address is written
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = clr_start ? CLEAR : IDLE;
         CLEAR:   state_next_s = clr_last_s ? IDLE : CLEAR;
         default: state_next_s = IDLE;
      endcase
   end

   // RAM port drive; address and data hold their last values when idle
   always_comb begin
      ram_ce_s  = 1'b0;
      ram_wre_s = 1'b0;
      ram_ad_s  = last_ad_r;
      ram_din_s = last_din_r;
      case (state_r)
         IDLE: begin
            if (gnt_s[0]) begin
               ram_ce_s  = 1'b1;
               ram_wre_s = a_we;
               ram_ad_s  = a_addr;
               ram_din_s = a_wdata;
            end else if (gnt_s[1]) begin
               ram_ce_s  = 1'b1;
               ram_wre_s = b_we;
               ram_ad_s  = b_addr;
               ram_din_s = b_wdata;
            end else begin
               ram_ce_s  = 1'b0;
               ram_wre_s = 1'b0;
            end
         end
         CLEAR: begin
            ram_ce_s  = 1'b1;
            ram_wre_s = 1'b1;
            ram_ad_s  = clr_cnt_r;
            ram_din_s = CLR_VALUE;
         end
         default: begin
            ram_ce_s  = 1'b0;
            ram_wre_s = 1'b0;
         end
      endcase
   end

   // fill address counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt_r <= {ADDR_W{1'b0}};
      end else if (idle_s && clr_start) begin
         clr_cnt_r <= {ADDR_W{1'b0}};
      end else if (state_r == CLEAR) begin
         clr_cnt_r <= clr_cnt_r + CNT_ONE;
      end else begin
         clr_cnt_r <= clr_cnt_r;
      end
   end

   // completion pulse in the first cycle back in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_done_r <= 1'b0;
      end else begin
         clr_done_r <= (state_r == CLEAR) && clr_last_s;
      end
   end

   // remember last issued address/data so the bus stays quiet between accesses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ad_r  <= {ADDR_W{1'b0}};
         last_din_r <= {DATA_W{1'b0}};
      end else if (ram_ce_s) begin
         last_ad_r  <= ram_ad_s;
         last_din_r <= ram_din_s;
      end else begin
         last_ad_r  <= last_ad_r;
         last_din_r <= last_din_r;
      end
   end

   // read-return tag: owner of the read issued last cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_a_r <= 1'b0;
         rd_b_r <= 1'b0;
      end else begin
         rd_a_r <= gnt_s[0] & ~a_we;
         rd_b_r <= gnt_s[1] & ~b_we;
      end
   end

`ifdef SP_RAM_ARB_OUTREG_EN
   logic              a_rvalid_r;
   logic              b_rvalid_r;
   logic [DATA_W-1:0] a_rdata_r;
   logic [DATA_W-1:0] b_rdata_r;

   // capture ram_dout per owner; data holds until that owner's next read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rvalid_r <= 1'b0;
         b_rvalid_r <= 1'b0;
         a_rdata_r  <= {DATA_W{1'b0}};
         b_rdata_r  <= {DATA_W{1'b0}};
      end else begin
         a_rvalid_r <= rd_a_r;
         b_rvalid_r <= rd_b_r;
         a_rdata_r  <= rd_a_r ? ram_dout : a_rdata_r;
         b_rdata_r  <= rd_b_r ? ram_dout : b_rdata_r;
      end
   end

   assign a_rvalid = a_rvalid_r;
   assign b_rvalid = b_rvalid_r;
   assign a_rdata  = a_rdata_r;
   assign b_rdata  = b_rdata_r;
`else
   assign a_rvalid = rd_a_r;
   assign b_rvalid = rd_b_r;
   assign a_rdata  = rd_a_r ? ram_dout : {DATA_W{1'b0}};
   assign b_rdata  = rd_b_r ? ram_dout : {DATA_W{1'b0}};
`endif

   assign a_gnt     = gnt_s[0];
   assign b_gnt     = gnt_s[1];
   assign clr_busy  = (state_r == CLEAR);
   assign clr_done  = clr_done_r;
   assign ram_ce    = ram_ce_s;
   assign ram_wre   = ram_wre_s;
   assign ram_ad    = ram_ad_s;
   assign ram_din   = ram_din_s;
   assign ram_oce   = 1'b1;
   assign ram_reset = 1'b0;

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Shares one 8-bit x 16K single-port block-RAM buffer between two requesters: A (host/UART load path) and B (AES engine).
- Issues at most one RAM access per cycle using round-robin arbitration.
- Returns read data with fixed latency.
- Contains a zero-fill engine that clears the whole buffer on command, blocking both requesters while it runs.

Parameters:
- ADDR_W, 14, RAM address width (depth 2^ADDR_W)
- DATA_W, 8, RAM data width
- CLR_VALUE, 8'h00, word written by the zero-fill engine

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr_start  in  1  pulse: start a buffer clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse on clear completion
- a_req  in  1  requester A access request
- a_we  in  1  A: 1=write, 0=read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A access issued this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_W  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- ram_ce  out  1  RAM clock enable
- ram_oce  out  1  RAM output clock enable
- ram_wre  out  1  RAM write enable
- ram_ad  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_reset  out  1  RAM output reset
- ram_dout  in  DATA_W  RAM read data (bypass read mode: valid one cycle after the access edge)

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE; clear counter = 0; RR pointer = "B last", so A wins first.
  - All outputs 0: gnt, rvalid, clr_busy, clr_done, ram_ce, ram_wre, ram_ad, ram_din, rdata.
- Constant outputs: ram_oce tied 1; ram_reset tied 0.
- FSM states: IDLE (arbitrate), CLEAR (fill).
- Request rules:
  - Requester holds req, we, addr and wdata stable until it sees gnt.
  - A gnt cycle completes the access; a new request may be presented the next cycle.
- IDLE arbitration:
  - gnt is combinational from req plus the registered RR pointer.
  - Only one req high: that requester is granted.
  - Both high: the requester not granted last is granted. The pointer updates on every grant.
  - Granted requester's we/addr/wdata drive ram_wre/ram_ad/ram_din; ram_ce = a_gnt | b_gnt.
  - No grant: ram_ce = 0, ram_wre = 0; ram_ad and ram_din hold their last values.
- Reads:
  - x_rvalid is registered high for exactly one cycle, the cycle after a read grant to x.
  - x_rdata = ram_dout, meaningful only while x_rvalid is high.
  - Writes never produce rvalid.
- Back-to-back:
  - A write to address N in cycle t followed by a read of N in cycle t+1 returns the new data.
  - Consecutive grants to the same requester are allowed when the other is idle.
- Clear:
  - clr_start in IDLE → CLEAR next cycle; counter = 0; clr_busy = 1.
  - Requests presented in the same cycle as clr_start are still granted that cycle.
  - In CLEAR: one write per cycle, ram_ad = counter, ram_din = CLR_VALUE, ram_wre = ram_ce = 1, both gnt = 0.
  - Counter increments every cycle. After the write to address 2^ADDR_W-1: → IDLE, clr_busy = 0, clr_done = 1 for one cycle.
  - Total duration: 2^ADDR_W cycles.
  - clr_start during CLEAR is ignored.
  - rvalid for a read granted in the cycle before CLEAR still fires in the first CLEAR cycle.
- rst_n asserted mid-clear: abort immediately, no clr_done; RAM contents are partially cleared and undefined.

Optional Feature:
- Macro: SP_RAM_ARB_OUTREG_EN.
- Defined:
  - ram_dout is captured into a per-requester rdata register, so read latency = 2 cycles (rvalid two cycles after gnt).
  - x_rdata holds its value until that requester's next read completes.
  - Reset value 0.
- Undefined: latency 1; rdata passes ram_dout through combinationally, as specified above.

Decomposition:
- Shared package sp_ram_pkg holds:
  - ADDR_W, DATA_W, RAM_DEPTH constants.
  - arb_state_t enum (IDLE, CLEAR).
  - Requester index enum (REQ_A, REQ_B).
- One sub-module: rr_arb2, a two-input round-robin arbiter (req[1:0], update, gnt[1:0], registered pointer).
- FSM, clear counter and read-return pipeline stay in the top module.

Test Plan:
- A writes 8'h5A @0x0010, then reads @0x0010 → a_gnt each cycle; a_rvalid 1 cycle after the read gnt with a_rdata = 8'h5A (2 cycles with OUTREG).
- A and B both req continuously (A rd 0x0001, B rd 0x0002) → grants alternate A,B,A,B starting with A; each rvalid routed only to its owner.
- B writes 8'hFF @0x3FFF, then @0x0000; issue clr_start → clr_busy for 16384 cycles, no gnt during that time, single clr_done pulse; reads of 0x3FFF and 0x0000 return 8'h00.
- clr_start in the same cycle as an A read of 0x0100 (preloaded 8'h33) → A granted; a_rvalid with 8'h33 in the first CLEAR cycle.
- rst_n low at clear count 0x2000 → all outputs 0 asynchronously, no clr_done; after release, A is granted first.
- clr_start pulsed again mid-clear → ignored; exactly one clr_done, 16384 cycles after the first clr_start.
